// File: rtl/reg_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: register-address
// constants, forwarding-select encodings and the per-stage entry record.
package pipeline_defs;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwdSelT;

    typedef struct packed {
        logic                  valid;
        logic                  wr;
        logic [REG_ADDR_W-1:0] dest;
        logic                  load;
    } stageEntryT;

    // A stage satisfies a source read only if it really writes that register;
    // $0 is never a dependency.
    function automatic logic destMatch(
        input stageEntryT            entry,
        input logic [REG_ADDR_W-1:0] src,
        input logic                  uses
    );
        return entry.valid & entry.wr & (entry.dest == src) & (src != REG_ZERO) & uses;
    endfunction

endpackage

// File: rtl/reg_hazard_ctrl_stage_reg.sv
// One pipeline-stage entry register for hazard tracking; a bubble load
// clears the whole entry so stale fields never linger behind valid=0.
module hazard_stage_reg
    import pipeline_defs::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bubble,
    input  stageEntryT entryIn,
    output stageEntryT entryOut
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entryOut <= '0;
        end else if (bubble) begin
            entryOut <= '0;
        end else begin
            entryOut <= entryIn;
        end
    end

endmodule

// File: rtl/reg_hazard_ctrl.sv
// Writeback-register selection, RAW hazard stall and EX forwarding selects
// for a 5-stage MIPS pipeline; tracks destinations through EX/MEM/WB.
module reg_hazard_ctrl
    import pipeline_defs::*;
#(
    parameter int unsigned FORWARDING  = 1,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic [REG_ADDR_W-1:0]  id_rs,
    input  logic [REG_ADDR_W-1:0]  id_rt,
    input  logic [REG_ADDR_W-1:0]  id_rd,
    input  logic                   id_reg_dst,
    input  logic                   id_reg_write,
    input  logic                   id_mem_to_reg,
    input  logic                   id_uses_rs,
    input  logic                   id_uses_rt,
    input  logic                   flush,
    output logic                   stall,
    output logic [1:0]             ex_fwd_a,
    output logic [1:0]             ex_fwd_b,
    output logic                   wb_we,
    output logic [REG_ADDR_W-1:0]  wb_addr,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic [REG_ADDR_W-1:0] idDest;
    stageEntryT            idEntry;
    stageEntryT            exEntry;
    stageEntryT            memEntry;
    stageEntryT            wbEntry;
    logic                  exBubble;
    logic                  stallInt;

    logic [REG_ADDR_W-1:0] exRs;
    logic [REG_ADDR_W-1:0] exRt;
    logic                  exUsesRs;
    logic                  exUsesRt;

    fwdSelT                fwdA;
    fwdSelT                fwdB;

    assign idDest = id_reg_dst ? id_rd : id_rt;

    always_comb begin
        idEntry       = '0;
        idEntry.valid = 1'b1;
        idEntry.wr    = id_reg_write & (idDest != REG_ZERO);
        idEntry.dest  = idDest;
        idEntry.load  = id_mem_to_reg;
    end

    // Stall is a function of the decode inputs and registered stage state only.
    always_comb begin
        stallInt = 1'b0;
        if (FORWARDING != 0) begin
            stallInt = id_valid & exEntry.load &
                       (destMatch(exEntry, id_rs, id_uses_rs) |
                        destMatch(exEntry, id_rt, id_uses_rt));
        end else begin
            stallInt = id_valid &
                       (destMatch(exEntry,  id_rs, id_uses_rs) |
                        destMatch(exEntry,  id_rt, id_uses_rt) |
                        destMatch(memEntry, id_rs, id_uses_rs) |
                        destMatch(memEntry, id_rt, id_uses_rt));
        end
    end

    assign exBubble = ~(id_valid & ~stallInt & ~flush);

    hazard_stage_reg uEx (
        .clk      (clk),
        .rst_n    (rst_n),
        .bubble   (exBubble),
        .entryIn  (idEntry),
        .entryOut (exEntry)
    );

    hazard_stage_reg uMem (
        .clk      (clk),
        .rst_n    (rst_n),
        .bubble   (1'b0),
        .entryIn  (exEntry),
        .entryOut (memEntry)
    );

    hazard_stage_reg uWb (
        .clk      (clk),
        .rst_n    (rst_n),
        .bubble   (1'b0),
        .entryIn  (memEntry),
        .entryOut (wbEntry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exRs     <= '0;
            exRt     <= '0;
            exUsesRs <= 1'b0;
            exUsesRt <= 1'b0;
        end else if (exBubble) begin
            exRs     <= '0;
            exRt     <= '0;
            exUsesRs <= 1'b0;
            exUsesRt <= 1'b0;
        end else begin
            exRs     <= id_rs;
            exRt     <= id_rt;
            exUsesRs <= id_uses_rs;
            exUsesRt <= id_uses_rt;
        end
    end

    // MEM is the younger producer, so it takes priority over WB.
    always_comb begin
        fwdA = FWD_REG;
        fwdB = FWD_REG;
        if ((FORWARDING != 0) && exEntry.valid) begin
            if (destMatch(memEntry, exRs, exUsesRs)) begin
                fwdA = FWD_MEM;
            end else if (destMatch(wbEntry, exRs, exUsesRs)) begin
                fwdA = FWD_WB;
            end
            if (destMatch(memEntry, exRt, exUsesRt)) begin
                fwdB = FWD_MEM;
            end else if (destMatch(wbEntry, exRt, exUsesRt)) begin
                fwdB = FWD_WB;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stallInt && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall    = stallInt;
    assign ex_fwd_a = fwdA;
    assign ex_fwd_b = fwdB;
    assign wb_we    = wbEntry.valid & wbEntry.wr;
    assign wb_addr  = wbEntry.dest;

endmodule

// File: tb/tb_reg_hazard_ctrl.sv
// Self-checking bench for reg_hazard_ctrl: a forwarding instance checked by a
// writeback scoreboard plus directed hazard checks, and a non-forwarding instance.
module tb_reg_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        idValid1, idValid0;
    logic [4:0]  idRs, idRt, idRd;
    logic        idRegDst, idRegWrite, idMemToReg, idUsesRs, idUsesRt;
    logic        flush;

    logic        stall1, stall0;
    logic [1:0]  fwdA1, fwdB1, fwdA0, fwdB0;
    logic        wbWe1, wbWe0;
    logic [4:0]  wbAddr1, wbAddr0;
    logic [15:0] stallCnt1, stallCnt0;

    int          checkCnt = 0;
    int          passCnt  = 0;
    logic [4:0]  expQ[$];

    always #5 clk = ~clk;

    reg_hazard_ctrl #(.FORWARDING(1), .STALL_CNT_W(16)) dutFwd (
        .clk(clk), .rst_n(rst_n), .id_valid(idValid1),
        .id_rs(idRs), .id_rt(idRt), .id_rd(idRd), .id_reg_dst(idRegDst),
        .id_reg_write(idRegWrite), .id_mem_to_reg(idMemToReg),
        .id_uses_rs(idUsesRs), .id_uses_rt(idUsesRt), .flush(flush),
        .stall(stall1), .ex_fwd_a(fwdA1), .ex_fwd_b(fwdB1),
        .wb_we(wbWe1), .wb_addr(wbAddr1), .stall_cnt(stallCnt1)
    );

    reg_hazard_ctrl #(.FORWARDING(0), .STALL_CNT_W(16)) dutNoFwd (
        .clk(clk), .rst_n(rst_n), .id_valid(idValid0),
        .id_rs(idRs), .id_rt(idRt), .id_rd(idRd), .id_reg_dst(idRegDst),
        .id_reg_write(idRegWrite), .id_mem_to_reg(idMemToReg),
        .id_uses_rs(idUsesRs), .id_uses_rt(idUsesRt), .flush(flush),
        .stall(stall0), .ex_fwd_a(fwdA0), .ex_fwd_b(fwdB0),
        .wb_we(wbWe0), .wb_addr(wbAddr0), .stall_cnt(stallCnt0)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCnt++;
        if (got === exp) passCnt++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Writeback scoreboard for the forwarding instance.
    always @(negedge clk) begin
        if (rst_n && wbWe1) begin
            if (expQ.size() == 0) checkVal("wb_spurious", 32'(wbWe1), 0);
            else checkVal("wb_addr", 32'(wbAddr1), 32'(expQ.pop_front()));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doReset();
        rst_n    = 1'b0;
        idValid0 = 1'b0;
        idValid1 = 1'b0;
        flush    = 1'b0;
        expQ.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Holds the instruction through nStall expected stall cycles, then lets it issue.
    task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic regDst, input logic regWrite, input logic memToReg,
                         input logic usesRs, input logic usesRt,
                         input int nStall, input bit fl, input bit toFwd0);
        logic [4:0] dest;
        dest       = regDst ? rd : rt;
        idRs       = rs;
        idRt       = rt;
        idRd       = rd;
        idRegDst   = regDst;
        idRegWrite = regWrite;
        idMemToReg = memToReg;
        idUsesRs   = usesRs;
        idUsesRt   = usesRt;
        flush      = fl;
        if (toFwd0) idValid0 = 1'b1;
        else idValid1 = 1'b1;
        if (fl) begin
            @(negedge clk);
            checkVal("stall_flush", 32'(toFwd0 ? stall0 : stall1), (nStall > 0) ? 1 : 0);
        end else begin
            for (int i = 0; i <= nStall; i++) begin
                if (i > 0) begin
                    @(posedge clk);
                    #1;
                end
                @(negedge clk);
                checkVal("stall", 32'(toFwd0 ? stall0 : stall1), (i < nStall) ? 1 : 0);
                if (i == nStall && !toFwd0 && regWrite && dest != 5'd0) expQ.push_back(dest);
            end
        end
        @(posedge clk);
        #1;
        idValid0 = 1'b0;
        idValid1 = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic alu(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        issue(rs, rt, rd, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [4:0] rs, input logic [4:0] rt);
        issue(rs, rt, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1;
        {idValid0, idValid1, flush} = '0;
        {idRs, idRt, idRd} = '0;
        {idRegDst, idRegWrite, idMemToReg, idUsesRs, idUsesRt} = '0;
        #1 rst_n = 1'b0;
        #2;
        checkVal("rst_stall",   32'(stall1),    0);
        checkVal("rst_wb_we",   32'(wbWe1),     0);
        checkVal("rst_wb_addr", 32'(wbAddr1),   0);
        checkVal("rst_cnt",     32'(stallCnt1), 0);
        checkVal("rst_fwd_a",   32'(fwdA1),     0);
        checkVal("rst_fwd_b",   32'(fwdB1),     0);
        checkVal("rst0_wb_we",  32'(wbWe0),     0);
        doReset();

        // Destination select: rd with RegDst=1, rt with RegDst=0, 3 cycles to WB.
        issue(5'd1, 5'd24, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        idle(2);
        checkVal("dst_rd_we",   32'(wbWe1),   1);
        checkVal("dst_rd_addr", 32'(wbAddr1), 7);
        issue(5'd1, 5'd24, 5'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        idle(2);
        checkVal("dst_rt_we",   32'(wbWe1),   1);
        checkVal("dst_rt_addr", 32'(wbAddr1), 24);
        idle(2);

        // Load-use: one bubble, then WB forwarding to operand A.
        load(5'd1, 5'd8);
        issue(5'd8, 5'd2, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b0);
        checkVal("lu_fwd_a", 32'(fwdA1),     2);
        checkVal("lu_fwd_b", 32'(fwdB1),     0);
        checkVal("lu_cnt",   32'(stallCnt1), 1);
        idle(4);

        // ALU forwarding from MEM, then from WB with a gap instruction.
        doReset();
        alu(5'd2, 5'd3, 5'd5);
        alu(5'd5, 5'd5, 5'd6);
        checkVal("alu_mem_a", 32'(fwdA1), 1);
        checkVal("alu_mem_b", 32'(fwdB1), 1);
        idle(3);
        alu(5'd2, 5'd3, 5'd5);
        alu(5'd1, 5'd2, 5'd11);
        alu(5'd5, 5'd5, 5'd6);
        checkVal("alu_wb_a",  32'(fwdA1),     2);
        checkVal("alu_wb_b",  32'(fwdB1),     2);
        checkVal("alu_cnt",   32'(stallCnt1), 0);
        idle(4);

        // Two writers of $3: MEM has priority.
        alu(5'd1, 5'd2, 5'd3);
        alu(5'd1, 5'd2, 5'd3);
        alu(5'd3, 5'd4, 5'd12);
        checkVal("dbl_fwd_a", 32'(fwdA1), 1);
        checkVal("dbl_fwd_b", 32'(fwdB1), 0);
        idle(4);

        // Register zero never hazards nor writes.
        issue(5'd1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        issue(5'd0, 5'd0, 5'd13, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        checkVal("r0_fwd_a", 32'(fwdA1), 0);
        checkVal("r0_fwd_b", 32'(fwdB1), 0);
        idle(1);
        checkVal("r0_wb_we", 32'(wbWe1), 0);
        idle(3);

        // Flush: stall still reported, EX gets a bubble either way.
        doReset();
        load(5'd1, 5'd8);
        issue(5'd8, 5'd2, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1'b1, 1'b0);
        checkVal("fl_ex_bubble", 32'(fwdA1),     0);
        checkVal("fl_cnt",       32'(stallCnt1), 1);
        issue(5'd1, 5'd2, 5'd11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b0);
        idle(4);

        // Reset mid-stream with EX/MEM/WB all valid and a stall pending.
        doReset();
        load(5'd1, 5'd8);
        issue(5'd8, 5'd2, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b0);
        alu(5'd1, 5'd2, 5'd20);
        alu(5'd1, 5'd2, 5'd21);
        load(5'd1, 5'd22);
        idRs = 5'd22; idRt = 5'd2; idRd = 5'd14;
        idRegDst = 1'b1; idRegWrite = 1'b1; idMemToReg = 1'b0;
        idUsesRs = 1'b1; idUsesRt = 1'b1; idValid1 = 1'b1;
        @(negedge clk);
        checkVal("pre_rst_stall", 32'(stall1),    1);
        checkVal("pre_rst_cnt",   32'(stallCnt1), 1);
        #2;
        rst_n = 1'b0;
        expQ.delete();
        idValid1 = 1'b0;
        #1;
        checkVal("mid_rst_stall",   32'(stall1),    0);
        checkVal("mid_rst_wb_we",   32'(wbWe1),     0);
        checkVal("mid_rst_wb_addr", 32'(wbAddr1),   0);
        checkVal("mid_rst_cnt",     32'(stallCnt1), 0);
        checkVal("mid_rst_fwd_a",   32'(fwdA1),     0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(5);
        checkVal("post_rst_wb_we", 32'(wbWe1), 0);

        // No forwarding: a dependent reader waits out EX and MEM.
        doReset();
        issue(5'd2, 5'd3, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1);
        issue(5'd9, 5'd2, 5'd13, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2, 1'b0, 1'b1);
        checkVal("nf_cnt",   32'(stallCnt0), 2);
        checkVal("nf_fwd_a", 32'(fwdA0),     0);
        checkVal("nf_fwd_b", 32'(fwdB0),     0);
        idle(4);

        checkVal("sb_drained", 32'(expQ.size()), 0);
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule

// File: doc/reg_hazard_ctrl.md
Name: reg_hazard_ctrl

Overview:
- Sequences writeback-register selection and hazard control for the 5-stage MIPS pipeline.
- Resolves each decoded instruction's destination register: rd when RegDst=1, rt when RegDst=0.
- Tracks in-flight destinations through the EX/MEM/WB stages.
- Issues a stall on read-after-write hazards and drives the EX-stage forwarding selects and the register-file write port.

Parameters:
- FORWARDING, 1: 1 = forward from MEM/WB stages; stall only on load-use. 0 = stall on any EX/MEM dependency.
- STALL_CNT_W, 16: width of the saturating stall-cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode stage holds a valid instruction.
- id_rs  in  5  source register A.
- id_rt  in  5  source register B / I-type destination.
- id_rd  in  5  R-type destination.
- id_reg_dst  in  1  RegDst: 1 selects rd, 0 selects rt.
- id_reg_write  in  1  instruction writes the register file.
- id_mem_to_reg  in  1  instruction is a load.
- id_uses_rs  in  1  rs is read.
- id_uses_rt  in  1  rt is read as a source.
- flush  in  1  squash the decode instruction (insert bubble into EX).
- stall  out  1  hold PC and IF/ID this cycle (combinational).
- ex_fwd_a  out  2  EX operand A source: 00 regfile, 01 MEM stage, 10 WB stage.
- ex_fwd_b  out  2  EX operand B source, same encoding.
- wb_we  out  1  register-file write enable.
- wb_addr  out  5  register-file write address.
- stall_cnt  out  STALL_CNT_W  count of stall cycles, saturating.

Behaviour:
- Clock and reset: one clock (clk). rst_n is asynchronous, active-low. Reset clears all stage valid bits and all stored fields, and zeroes stall_cnt.
- Outputs in reset: stall=0, ex_fwd_a=ex_fwd_b=00, wb_we=0, wb_addr=0.
- Destination: id_dest = id_reg_dst ? id_rd : id_rt.
- Write qualification: an entry writes only if id_reg_write=1 and id_dest != 0. Register $0 never creates a hazard and is never written.
- Stage registers EX, MEM, WB each hold: valid, wr, dest[4:0], load. EX also holds rs, rt, uses_rs, uses_rt.
- Every rising edge: WB<=MEM, MEM<=EX.
- EX loads the decode instruction when id_valid & ~stall & ~flush; otherwise EX loads a bubble (valid=0).
- Issue-to-writeback latency is 3 cycles: wb_we/wb_addr reflect the WB stage register (wb_we = WB.valid & WB.wr).
- Hazard match: src matches stage S when S.valid & S.wr & S.dest==src & src!=0 & the corresponding uses flag is set.
- Stall rule, FORWARDING=1: stall = id_valid & match against EX where EX.load=1. This gives exactly one bubble per load-use.
- Stall rule, FORWARDING=0: stall = id_valid & match against EX or MEM. WB is not checked because the regfile writes first half-cycle.
- Stall boundaries:
  - flush has priority over stall for EX loading (bubble either way).
  - stall is still reported while flush is high.
  - stall depends on current state only; no combinational path from stall back into the match logic.
- Forwarding (FORWARDING=1), combinational on EX contents:
  - ex_fwd_a = 01 if MEM matches EX.rs, else 10 if WB matches EX.rs, else 00. MEM wins when both match.
  - ex_fwd_b is the same, using EX.rt.
- Forwarding (FORWARDING=0): ex_fwd_a and ex_fwd_b are tied to 00.
- Forwarding for a bubble in EX: both selects are 00.
- stall_cnt increments on each rising edge where stall=1 and holds at all-ones.
- Reset mid-operation: all in-flight entries are discarded. No write is issued after rst_n deasserts until a new instruction reaches WB.

Decomposition:
- Shared package (pipeline_defs) holds:
  - REG_ADDR_W=5, REG_ZERO=5'd0.
  - Forward encodings FWD_REG=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
  - The stage-entry record typedef (valid, wr, dest, load).
- One natural sub-module: hazard_stage_reg. It is the per-stage entry register with async reset and a bubble-load input, instantiated three times.
- Destination mux and match comparators stay inline.

Test Plan:
- Reset: hold rst_n=0 mid-stream with EX/MEM/WB valid -> stall=0, wb_we=0, wb_addr=0, stall_cnt=0 immediately, without waiting for a clock edge.
- Dest select: issue reg_write, RegDst=1, rt=24, rd=7 -> 3 cycles later wb_we=1, wb_addr=7. Repeat with RegDst=0 -> wb_addr=24.
- Load-use (FORWARDING=1): load dest=$8, then add with rs=$8 -> stall=1 for exactly one cycle, stall_cnt=1. The add then reaches EX with ex_fwd_a=10.
- ALU forwarding: add dest=$5, then sub rs=$5, rt=$5 -> no stall, ex_fwd_a=ex_fwd_b=01. Insert one independent instruction between them instead -> selects=10.
- Double match: two back-to-back writes to $3, then a reader of $3 -> ex_fwd_a=01 (MEM priority).
- Register zero / flush / FORWARDING=0:
  - Writer to $0 followed by a reader of $0 -> no stall, selects 00, wb_we=0.
  - flush=1 with a dependent load -> EX holds a bubble.
  - FORWARDING=0 with an add to $9 then a reader of $9 -> stall for 2 cycles.
